// File: rtl/flexdpe_sched.sv
// Job sequencer for one flexdpe instance.
// Each job is one stationary load, then N streaming beats, then a pipeline drain and a done pulse.
module flexdpe_sched #(
    parameter int IN_DATA_TYPE = 16,
    parameter int NUM_PES      = 32,
    parameter int LOG2_PES     = 5,
    parameter int CNT_W        = 11,
    parameter int PIPE_LAT     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [CNT_W-1:0]                 i_num_stream,
    input  logic                             i_abort,
    input  logic                             i_stat_valid,
    output logic                             o_stat_ready,
    input  logic [NUM_PES*IN_DATA_TYPE-1:0]  i_stat_data,
    input  logic [NUM_PES*LOG2_PES-1:0]      i_stat_dest,
    input  logic                             i_str_valid,
    output logic                             o_str_ready,
    input  logic [NUM_PES*IN_DATA_TYPE-1:0]  i_str_data,
    input  logic [NUM_PES*LOG2_PES-1:0]      i_str_dest,
    input  logic [NUM_PES*LOG2_PES-1:0]      i_str_vn,
    output logic                             o_data_valid,
    output logic [NUM_PES*IN_DATA_TYPE-1:0]  o_data_bus,
    output logic                             o_stationary,
    output logic [NUM_PES*LOG2_PES-1:0]      o_dest_bus,
    output logic [NUM_PES*LOG2_PES-1:0]      o_vn_seperator,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [CNT_W-1:0]                 o_stream_cnt
);

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_STAT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     n_q;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 stat_fire;
    logic                 str_fire;
    logic                 start_ok;

    // NOTE: readies are masked by i_abort so a beat offered in the abort cycle never completes a handshake.
    assign o_stat_ready = (state == S_LOAD_STAT) && !i_abort;
    assign o_str_ready  = (state == S_STREAM) && (o_stream_cnt < n_q) && !i_abort;
    assign stat_fire    = o_stat_ready && i_stat_valid;
    assign str_fire     = o_str_ready && i_str_valid;
    assign start_ok     = (state == S_IDLE) && i_start && !i_abort;
    assign o_busy       = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        if (i_abort) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:      if (i_start) state_nx = S_LOAD_STAT;
                S_LOAD_STAT: if (stat_fire) state_nx = (n_q == '0) ? S_DRAIN : S_STREAM;
                S_STREAM:    if (str_fire && ((o_stream_cnt + CNT_W'(1)) == n_q)) state_nx = S_DRAIN;
                S_DRAIN:     if (drain_cnt == '0) state_nx = S_DONE;
                S_DONE:      state_nx = S_IDLE;
                default:     state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            n_q          <= '0;
            o_stream_cnt <= '0;
            drain_cnt    <= '0;
            o_done       <= 1'b0;
        end else begin
            state  <= state_nx;
            o_done <= (state == S_DONE) && !i_abort;

            if (start_ok) begin
                n_q          <= i_num_stream;
                o_stream_cnt <= '0;
            end else if (str_fire) begin
                o_stream_cnt <= o_stream_cnt + CNT_W'(1);
            end

            if ((state != S_DRAIN) && (state_nx == S_DRAIN)) begin
                drain_cnt <= DRAIN_W'(PIPE_LAT - 1);
            end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

    // Issue register: one-cycle latency, all-zero in any cycle without an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data_valid   <= 1'b0;
            o_stationary   <= 1'b0;
            o_data_bus     <= '0;
            o_dest_bus     <= '0;
            o_vn_seperator <= '0;
        end else if (stat_fire) begin
            o_data_valid   <= 1'b1;
            o_stationary   <= 1'b1;
            o_data_bus     <= i_stat_data;
            o_dest_bus     <= i_stat_dest;
            o_vn_seperator <= '0;
        end else if (str_fire) begin
            o_data_valid   <= 1'b1;
            o_stationary   <= 1'b0;
            o_data_bus     <= i_str_data;
            o_dest_bus     <= i_str_dest;
            o_vn_seperator <= i_str_vn;
        end else begin
            o_data_valid   <= 1'b0;
            o_stationary   <= 1'b0;
            o_data_bus     <= '0;
            o_dest_bus     <= '0;
            o_vn_seperator <= '0;
        end
    end

endmodule

// File: tb/tb_flexdpe_sched.sv
// Directed self-checking bench for flexdpe_sched: job timing, gaps, ignored starts, abort and async reset.
module tb_flexdpe_sched;

    localparam int IN_DATA_TYPE = 16;
    localparam int NUM_PES      = 32;
    localparam int LOG2_PES     = 5;
    localparam int CNT_W        = 11;
    localparam int PIPE_LAT     = 8;
    localparam int DW           = NUM_PES * IN_DATA_TYPE;
    localparam int AW           = NUM_PES * LOG2_PES;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [CNT_W-1:0] i_num_stream;
    logic             i_abort;
    logic             i_stat_valid;
    logic             o_stat_ready;
    logic [DW-1:0]    i_stat_data;
    logic [AW-1:0]    i_stat_dest;
    logic             i_str_valid;
    logic             o_str_ready;
    logic [DW-1:0]    i_str_data;
    logic [AW-1:0]    i_str_dest;
    logic [AW-1:0]    i_str_vn;
    logic             o_data_valid;
    logic [DW-1:0]    o_data_bus;
    logic             o_stationary;
    logic [AW-1:0]    o_dest_bus;
    logic [AW-1:0]    o_vn_seperator;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_stream_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    flexdpe_sched #(
        .IN_DATA_TYPE(IN_DATA_TYPE),
        .NUM_PES     (NUM_PES),
        .LOG2_PES    (LOG2_PES),
        .CNT_W       (CNT_W),
        .PIPE_LAT    (PIPE_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_num_stream  (i_num_stream),
        .i_abort       (i_abort),
        .i_stat_valid  (i_stat_valid),
        .o_stat_ready  (o_stat_ready),
        .i_stat_data   (i_stat_data),
        .i_stat_dest   (i_stat_dest),
        .i_str_valid   (i_str_valid),
        .o_str_ready   (o_str_ready),
        .i_str_data    (i_str_data),
        .i_str_dest    (i_str_dest),
        .i_str_vn      (i_str_vn),
        .o_data_valid  (o_data_valid),
        .o_data_bus    (o_data_bus),
        .o_stationary  (o_stationary),
        .o_dest_bus    (o_dest_bus),
        .o_vn_seperator(o_vn_seperator),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_stream_cnt  (o_stream_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] seed_word(input int s);
        return 32'(s) * 32'h9E37_79B9 + 32'h0000_1234;
    endfunction

    function automatic logic [DW-1:0] pat_d(input int s);
        return {(DW/32){seed_word(s)}};
    endfunction

    function automatic logic [AW-1:0] pat_a(input int s);
        return {(AW/32){seed_word(s) ^ 32'h0000_FFFF}};
    endfunction

    function automatic logic [AW-1:0] pat_v(input int s);
        return {(AW/32){~seed_word(s)}};
    endfunction

    task automatic set_str(input int s);
        i_str_data = pat_d(s);
        i_str_dest = pat_a(s);
        i_str_vn   = pat_v(s);
    endtask

    // Counts sample points until o_done is seen, bounded.
    task automatic wait_done(input string tag, input int exp);
        int n;
        n = 0;
        while (!o_done && n < 64) begin
            tick();
            n++;
        end
        check(tag, DW'(n), DW'(exp));
    endtask

    task automatic check_str_beat(input string tag, input int s, input int cnt);
        check({tag, "_valid"}, DW'(o_data_valid), DW'(1));
        check({tag, "_stat"},  DW'(o_stationary), DW'(0));
        check({tag, "_data"},  o_data_bus, pat_d(s));
        check({tag, "_dest"},  DW'(o_dest_bus), DW'(pat_a(s)));
        check({tag, "_vn"},    DW'(o_vn_seperator), DW'(pat_v(s)));
        check({tag, "_cnt"},   DW'(o_stream_cnt), DW'(cnt));
    endtask

    task automatic check_stat_beat(input string tag, input int s);
        check({tag, "_valid"}, DW'(o_data_valid), DW'(1));
        check({tag, "_stat"},  DW'(o_stationary), DW'(1));
        check({tag, "_data"},  o_data_bus, pat_d(s));
        check({tag, "_dest"},  DW'(o_dest_bus), DW'(pat_a(s)));
        check({tag, "_vn"},    DW'(o_vn_seperator), DW'(0));
    endtask

    initial begin
        int  beat;
        int  n;
        logic seen_rdy, seen_dv, seen_done;

        rst = 1'b1; i_start = 0; i_num_stream = '0; i_abort = 0;
        i_stat_valid = 1; i_stat_data = pat_d(99); i_stat_dest = pat_a(99);
        i_str_valid = 1; set_str(98);
        repeat (2) tick();

        // Reset state with both producers offering beats.
        check("rst_busy",      DW'(o_busy), DW'(0));
        check("rst_done",      DW'(o_done), DW'(0));
        check("rst_cnt",       DW'(o_stream_cnt), DW'(0));
        check("rst_valid",     DW'(o_data_valid), DW'(0));
        check("rst_bus",       o_data_bus, DW'(0));
        check("rst_stat_rdy",  DW'(o_stat_ready), DW'(0));
        rst = 1'b0;
        tick();
        check("idle_stat_rdy", DW'(o_stat_ready), DW'(0));
        check("idle_str_rdy",  DW'(o_str_ready), DW'(0));
        check("idle_valid",    DW'(o_data_valid), DW'(0));

        // 1: n=5, all valids held high.
        i_num_stream = 11'd5; i_start = 1;
        i_stat_data = pat_d(1); i_stat_dest = pat_a(1); set_str(11);
        tick();
        i_start = 0;
        check("t1_busy",     DW'(o_busy), DW'(1));
        check("t1_stat_rdy", DW'(o_stat_ready), DW'(1));
        check("t1_no_issue", DW'(o_data_valid), DW'(0));
        tick();
        check_stat_beat("t1_statbeat", 1);
        check("t1_cnt0", DW'(o_stream_cnt), DW'(0));
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_str_beat($sformatf("t1_beat%0d", k), 10 + k, k);
            set_str(11 + k);
        end
        wait_done("t1_done_lat", PIPE_LAT + 1);
        check("t1_idle_at_done", DW'(o_busy), DW'(0));
        check("t1_cnt_final",    DW'(o_stream_cnt), DW'(5));
        tick();
        check("t1_done_pulse",   DW'(o_done), DW'(0));

        // 2: n=0, stationary beat only.
        i_num_stream = 11'd0; i_start = 1;
        i_stat_data = pat_d(2); i_stat_dest = pat_a(2); set_str(21);
        tick();
        i_start = 0;
        tick();
        check_stat_beat("t2_statbeat", 2);
        seen_rdy = 0; seen_dv = 0; n = 0;
        while (!o_done && n < 64) begin
            if (o_str_ready) seen_rdy = 1;
            tick();
            if (!o_done && o_data_valid) seen_dv = 1;
            n++;
        end
        check("t2_done_lat",  DW'(n), DW'(PIPE_LAT + 1));
        check("t2_str_rdy",   DW'(seen_rdy), DW'(0));
        check("t2_no_issue",  DW'(seen_dv), DW'(0));
        check("t2_cnt_final", DW'(o_stream_cnt), DW'(0));

        // 3: n=4, streaming valid toggling 1010...
        i_num_stream = 11'd4; i_start = 1; i_str_valid = 0;
        i_stat_data = pat_d(3); i_stat_dest = pat_a(3);
        tick();
        i_start = 0;
        tick();
        check_stat_beat("t3_statbeat", 3);
        i_stat_valid = 0;
        beat = 0;
        for (int c = 0; c < 7; c++) begin
            i_str_valid = (c % 2 == 0);
            set_str(30 + c);
            tick();
            if (c % 2 == 0) begin
                beat++;
                check_str_beat($sformatf("t3_beat%0d", beat), 30 + c, beat);
            end else begin
                check($sformatf("t3_gap%0d_valid", c), DW'(o_data_valid), DW'(0));
                check($sformatf("t3_gap%0d_data", c),  o_data_bus, DW'(0));
                check($sformatf("t3_gap%0d_dest", c),  DW'(o_dest_bus), DW'(0));
                check($sformatf("t3_gap%0d_vn", c),    DW'(o_vn_seperator), DW'(0));
            end
        end
        i_str_valid = 0;
        wait_done("t3_done_lat",  PIPE_LAT + 1);
        check("t3_cnt_final", DW'(o_stream_cnt), DW'(4));

        // 4: i_start held high through the whole job, including DONE.
        i_num_stream = 11'd2; i_start = 1; i_stat_valid = 1; i_str_valid = 1;
        i_stat_data = pat_d(4); i_stat_dest = pat_a(4); set_str(41);
        tick();
        tick();
        check_stat_beat("t4_statbeat", 4);
        tick();
        check_str_beat("t4_beat1", 41, 1);
        set_str(42);
        tick();
        check_str_beat("t4_beat2", 42, 2);
        wait_done("t4_done_lat", PIPE_LAT + 1);
        i_start = 0;
        check("t4_idle_after_done", DW'(o_busy), DW'(0));
        tick();
        check("t4_still_idle", DW'(o_busy), DW'(0));
        check("t4_single_done", DW'(o_done), DW'(0));
        i_num_stream = 11'd1; i_start = 1;
        i_stat_data = pat_d(5); i_stat_dest = pat_a(5); set_str(45);
        tick();
        i_start = 0;
        check("t4_job2_stat_rdy", DW'(o_stat_ready), DW'(1));
        tick();
        check_stat_beat("t4_job2_stat", 5);
        tick();
        check_str_beat("t4_job2_beat1", 45, 1);
        wait_done("t4_job2_done_lat", PIPE_LAT + 1);

        // 5: abort on the 3rd streaming handshake of n=6.
        i_num_stream = 11'd6; i_start = 1;
        i_stat_data = pat_d(6); i_stat_dest = pat_a(6); set_str(51);
        tick();
        i_start = 0;
        tick();
        check_stat_beat("t5_statbeat", 6);
        tick();
        check_str_beat("t5_beat1", 51, 1);
        set_str(52);
        tick();
        check_str_beat("t5_beat2", 52, 2);
        set_str(53);
        i_abort = 1;
        tick();
        i_abort = 0;
        check("t5_busy",  DW'(o_busy), DW'(0));
        check("t5_valid", DW'(o_data_valid), DW'(0));
        check("t5_bus",   o_data_bus, DW'(0));
        check("t5_cnt",   DW'(o_stream_cnt), DW'(2));
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_done || o_busy) seen_done = 1;
            tick();
        end
        check("t5_no_done", DW'(seen_done), DW'(0));
        check("t5_cnt_hold", DW'(o_stream_cnt), DW'(2));

        // 6: async reset in the middle of DRAIN.
        i_num_stream = 11'd3; i_start = 1;
        i_stat_data = pat_d(7); i_stat_dest = pat_a(7); set_str(61);
        tick();
        i_start = 0;
        tick();
        check_stat_beat("t6_statbeat", 7);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_str_beat($sformatf("t6_beat%0d", k), 60 + k, k);
            set_str(61 + k);
        end
        tick();
        tick();
        check("t6_busy_mid_drain", DW'(o_busy), DW'(1));
        #2 rst = 1;
        #1;
        check("t6_rst_busy",  DW'(o_busy), DW'(0));
        check("t6_rst_cnt",   DW'(o_stream_cnt), DW'(0));
        check("t6_rst_done",  DW'(o_done), DW'(0));
        check("t6_rst_valid", DW'(o_data_valid), DW'(0));
        check("t6_rst_dest",  DW'(o_dest_bus), DW'(0));
        tick();
        rst = 0;
        i_num_stream = 11'd2; i_start = 1;
        i_stat_data = pat_d(8); i_stat_dest = pat_a(8); set_str(71);
        tick();
        i_start = 0;
        tick();
        check_stat_beat("t6_job2_stat", 8);
        tick();
        check_str_beat("t6_job2_beat1", 71, 1);
        set_str(72);
        tick();
        check_str_beat("t6_job2_beat2", 72, 2);
        wait_done("t6_job2_done_lat", PIPE_LAT + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
